// File: rtl/euros_para_centimos.sv
// Converts integer euros plus a cents fraction back into a saturated centimos total.
// The euro part is multiplied by 100 with one shift-add step per clock.
//
// state | meaning
// IDLE  | waiting for an input handshake
// MUL   | adding 100<<k for each set euro bit k, one bit per clock
// FRAC  | adding the fraction, flagging err/ovf, raising out_valid
// DONE  | holding the result until out_ready
module euros_para_centimos #(
  parameter int EURO_W = 10,
  parameter int FRAC_W = 10,
  parameter int CENT_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [EURO_W-1:0] eurosinteiros,
  input  logic [FRAC_W-1:0] eurosfracao,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CENT_W-1:0] centimos,
  output logic              err,
  output logic              ovf,
  output logic              busy
);

  localparam int ACC_W = EURO_W + 8;
  localparam int KW = (EURO_W > 1) ? $clog2(EURO_W) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(EURO_W - 1);
  localparam logic [ACC_W:0] CENT_MAX = (ACC_W + 1)'((1 << CENT_W) - 1);
  localparam logic [FRAC_W-1:0] FRAC_MAX = FRAC_W'(99);

  typedef enum logic [1:0] {IDLE, MUL, FRAC, DONE} state_t;

  state_t            state;
  logic [EURO_W-1:0] euro_q;
  logic [FRAC_W-1:0] frac_q;
  logic [ACC_W-1:0]  acc;
  logic [KW-1:0]     k;
  logic [ACC_W-1:0]  step;
  logic [ACC_W:0]    sum;

  always_comb begin
    step = ACC_W'(100) << k;
    sum  = {1'b0, acc} + (ACC_W + 1)'(frac_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      euro_q    <= '0;
      frac_q    <= '0;
      acc       <= '0;
      k         <= '0;
      out_valid <= 1'b0;
      centimos  <= '0;
      err       <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            euro_q <= eurosinteiros;
            frac_q <= eurosfracao;
            acc    <= '0;
            k      <= '0;
            state  <= MUL;
          end
        end
        MUL: begin
          // fixed EURO_W steps so latency never depends on the data
          if (euro_q[k]) acc <= acc + step;
          if (k == K_LAST) state <= FRAC;
          else k <= k + 1'b1;
        end
        FRAC: begin
          if (frac_q > FRAC_MAX) begin
            err      <= 1'b1;
            ovf      <= 1'b0;
            centimos <= '0;
          end else begin
            err <= 1'b0;
            if (sum > CENT_MAX) begin
              centimos <= '1;
              ovf      <= 1'b1;
            end else begin
              centimos <= sum[CENT_W-1:0];
              ovf      <= 1'b0;
            end
          end
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready = rst_n && (state == IDLE);
  assign busy     = (state == MUL) || (state == FRAC);

endmodule
